// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the multi-cycle RV32I datapath.
// These encodings are also used by the ALU control decoder and the datapath muxes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_src_decode.sv
// Immediate-format select, decoded straight from the instruction opcode.
module imm_src_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [1:0] immsrc
);

  // Opcode to immediate format; anything unrecognised falls back to I-type.
  always_comb begin
    immsrc = IMM_I;
    case (opcode)
      OP_LW:   immsrc = IMM_I;
      OP_I:    immsrc = IMM_I;
      OP_SW:   immsrc = IMM_S;
      OP_BEQ:  immsrc = IMM_B;
      OP_JAL:  immsrc = IMM_J;
      default: immsrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle RV32I datapath.
// Moore outputs decode from the state register; immsrc and pcwrite are the
// only paths that see the opcode / zero inputs combinationally.
// Optional build macro MAIN_CTRL_ILLEGAL_TRAP_EN: unknown opcodes trap and
// raise the sticky illegal_op flag instead of being skipped as nops.
module multicycle_main_control
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  output logic [1:0]       aluop,
  output logic [1:0]       alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       resultsrc,
  output logic [1:0]       immsrc,
  output logic             adrsrc,
  output logic             irwrite,
  output logic             regwrite,
  output logic             memwrite,
  output logic             pcwrite,
  output logic [CNT_W-1:0] instret,
  output logic             illegal_op
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] instret_r;
  logic             irwrite_s;
  logic             regwrite_s;
  logic             memwrite_s;
  logic             branch_s;
  logic             pcupdate_s;
  logic             retire_s;

  imm_src_decode u_imm_src_decode (
    .opcode (opcode),
    .immsrc (immsrc)
  );

  // State register; reset always lands in a full fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    next_state_s = S_FETCH;
    aluop        = ALUOP_ADD;
    alusrca      = SRCA_PC;
    alusrcb      = SRCB_RD2;
    resultsrc    = RES_ALUOUT;
    adrsrc       = 1'b0;
    irwrite_s    = 1'b0;
    regwrite_s   = 1'b0;
    memwrite_s   = 1'b0;
    branch_s     = 1'b0;
    pcupdate_s   = 1'b0;
    retire_s     = 1'b0;
    case (state_r)
      S_FETCH: begin
        irwrite_s    = 1'b1;
        alusrcb      = SRCB_FOUR;
        resultsrc    = RES_ALURESULT;
        pcupdate_s   = 1'b1;
        next_state_s = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target into aluout while decoding.
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        case (opcode)
          OP_LW:   next_state_s = S_MEMADR;
          OP_SW:   next_state_s = S_MEMADR;
          OP_R:    next_state_s = S_EXECUTER;
          OP_I:    next_state_s = S_EXECUTEI;
          OP_BEQ:  next_state_s = S_BEQ;
          OP_JAL:  next_state_s = S_JAL;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
          default: next_state_s = S_TRAP;
`else
          default: next_state_s = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alusrca = SRCA_RD1;
        alusrcb = SRCB_IMM;
        if (opcode == OP_LW) begin
          next_state_s = S_MEMREAD;
        end else begin
          next_state_s = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        adrsrc       = 1'b1;
        next_state_s = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc    = RES_MEMDATA;
        regwrite_s   = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEMWRITE: begin
        adrsrc       = 1'b1;
        memwrite_s   = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_EXECUTER: begin
        alusrca      = SRCA_RD1;
        alusrcb      = SRCB_RD2;
        aluop        = ALUOP_FUNC;
        next_state_s = S_ALUWB;
      end
      S_EXECUTEI: begin
        alusrca      = SRCA_RD1;
        alusrcb      = SRCB_IMM;
        aluop        = ALUOP_FUNC;
        next_state_s = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_s   = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_BEQ: begin
        alusrca      = SRCA_RD1;
        alusrcb      = SRCB_RD2;
        aluop        = ALUOP_SUB;
        branch_s     = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JAL: begin
        // pc <= aluout (target); aluresult = oldpc + 4 becomes the link value.
        alusrca      = SRCA_OLDPC;
        alusrcb      = SRCB_FOUR;
        pcupdate_s   = 1'b1;
        next_state_s = S_ALUWB;
      end
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        next_state_s = S_TRAP;
      end
`endif
      default: begin
        next_state_s = S_FETCH;
      end
    endcase
  end

  // Write strobes are suppressed while reset is asserted so an abandoned
  // instruction leaves no architectural side effect.
  assign irwrite  = irwrite_s  & ~reset;
  assign regwrite = regwrite_s & ~reset;
  assign memwrite = memwrite_s & ~reset;
  assign pcwrite  = ~reset & (pcupdate_s | (branch_s & zero));

  // Retired-instruction counter, bumped on the edge leaving a final state.
  always_ff @(posedge clk) begin
    if (reset) begin
      instret_r <= {CNT_W{1'b0}};
    end else if (retire_s) begin
      instret_r <= instret_r + CNT_ONE;
    end else begin
      instret_r <= instret_r;
    end
  end

  assign instret = instret_r;

`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
  logic illegal_r;

  // Sticky flag set on the edge that enters TRAP; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_r <= 1'b0;
    end else if ((state_r == S_DECODE) && (next_state_s == S_TRAP)) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  assign illegal_op = illegal_r;
`else
  assign illegal_op = 1'b0;
`endif

endmodule
